// File: rtl/io_stream_bridge_if.sv
// Core- and UART-facing signal bundle of io_stream_bridge.
// The bridge takes the slave view; the core/UART side (or a bench) takes the master view.
interface io_stream_bridge_if;
  logic        out_issued;
  logic [31:0] out_data;
  logic        out_stall;
  logic        in_issued;
  logic        in_stall;
  logic [31:0] in_data;
  logic [31:0] status;
  logic [7:0]  led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_overflow;

  modport slave (
    input  out_issued, out_data, in_issued, status, tx_ready, rx_data, rx_valid,
    output out_stall, in_stall, in_data, led, tx_data, tx_valid, rx_overflow
  );

  modport master (
    output out_issued, out_data, in_issued, status, tx_ready, rx_data, rx_valid,
    input  out_stall, in_stall, in_data, led, tx_data, tx_valid, rx_overflow
  );
endinterface

// File: rtl/io_stream_bridge.sv
// Core I/O bridge: TX word FIFO + LSB-first byte serializer, RX byte assembler + word FIFO,
// and a registered LED copy of the core status word.
module io_stream_bridge #(
  parameter int unsigned TX_DEPTH_LOG2 = 4,
  parameter int unsigned RX_DEPTH_LOG2 = 4
) (
  input logic                clk,
  input logic                rst,
  io_stream_bridge_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [TX_DEPTH_LOG2:0] TX_FULL = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
  localparam logic [RX_DEPTH_LOG2:0] RX_FULL = {1'b1, {RX_DEPTH_LOG2{1'b0}}};

  // TX side
  logic [31:0]              tx_mem [2**TX_DEPTH_LOG2];
  logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_DEPTH_LOG2:0]   tx_count;
  logic                     tx_push, tx_pop, tx_empty, tx_hs;
  logic [0:0]               state;
  logic [31:0]              shift;
  logic [1:0]               byte_idx;

  assign bus.out_stall = (tx_count == TX_FULL);
  assign tx_empty      = (tx_count == '0);
  assign tx_push       = bus.out_issued && !bus.out_stall;
  assign bus.tx_valid  = (state == ST_SEND);
  assign bus.tx_data   = shift[7:0];
  assign tx_hs         = bus.tx_valid && bus.tx_ready;

  // Reload on the last byte's handshake keeps consecutive words gapless.
  always_comb begin
    tx_pop = 1'b0;
    case (state)
      ST_IDLE: tx_pop = !tx_empty;
      ST_SEND: tx_pop = tx_hs && (byte_idx == 2'd3) && !tx_empty;
      default: tx_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.out_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shift    <= '0;
      byte_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_pop) begin
            shift    <= tx_mem[tx_rd_ptr];
            byte_idx <= '0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_hs) begin
            byte_idx <= byte_idx + 2'd1;
            if (tx_pop) begin
              shift <= tx_mem[tx_rd_ptr];
            end else begin
              shift <= shift >> 8;
              if (byte_idx == 2'd3) state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RX side
  logic [31:0]              rx_mem [2**RX_DEPTH_LOG2];
  logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_DEPTH_LOG2:0]   rx_count;
  logic [1:0]               rx_idx;
  logic [23:0]              rx_acc;
  logic                     rx_word_done, rx_full, rx_push, rx_pop, rx_empty;

  assign rx_empty     = (rx_count == '0);
  assign rx_full      = (rx_count == RX_FULL);
  assign rx_word_done = bus.rx_valid && (rx_idx == 2'd3);
  assign rx_push      = rx_word_done && !rx_full;
  assign bus.in_stall = bus.in_issued && rx_empty;
  assign rx_pop       = bus.in_issued && !bus.in_stall;
  assign bus.in_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= {bus.rx_data, rx_acc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr       <= '0;
      rx_rd_ptr       <= '0;
      rx_count        <= '0;
      rx_idx          <= '0;
      rx_acc          <= '0;
      bus.rx_overflow <= 1'b0;
      bus.led         <= '0;
    end else begin
      bus.led <= bus.status[7:0];
      if (bus.rx_valid) begin
        rx_idx <= rx_idx + 2'd1;
        case (rx_idx)
          2'd0:    rx_acc[7:0]   <= bus.rx_data;
          2'd1:    rx_acc[15:8]  <= bus.rx_data;
          2'd2:    rx_acc[23:16] <= bus.rx_data;
          default: rx_acc        <= rx_acc;
        endcase
      end
      if (rx_word_done && rx_full) bus.rx_overflow <= 1'b1;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  logic unused_status;
  assign unused_status = &{1'b0, bus.status[31:8]};

endmodule

// File: tb/tb_io_stream_bridge.sv
// Self-checking bench for io_stream_bridge: directed scenarios plus a randomized run
// scored against a queue-based model of the byte stream and RX word buffer.
module tb_io_stream_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_stream_bridge_if bus ();

  io_stream_bridge #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  logic [7:0]  exp_bytes [$];
  logic [31:0] rx_q [$];
  logic [7:0]  part [$];
  logic [31:0] tw [18];
  logic [31:0] rw [17];
  logic [31:0] w, prev_status;
  logic [7:0]  held_byte, eb;
  logic        ovf_exp, tx_hold, out_hold, in_hold, pending, full_before;
  int          accepted, outstanding, in_p;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word_bytes(input logic [31:0] wd);
    for (int b = 0; b < 4; b++) exp_bytes.push_back(wd[8*b +: 8]);
  endtask

  // Drives one word LSB-first on consecutive cycles; returns at +1 of the following cycle.
  task automatic send_word(input logic [31:0] wd);
    for (int b = 0; b < 4; b++) begin
      next_cycle();
      bus.rx_valid = 1'b1;
      bus.rx_data  = wd[8*b +: 8];
    end
    next_cycle();
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.out_issued = 1'b0;
    bus.out_data   = '0;
    bus.in_issued  = 1'b0;
    bus.status     = 32'hFFFF_FFFF;
    bus.tx_ready   = 1'b0;
    bus.rx_data    = '0;
    bus.rx_valid   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_stall", bus.out_stall, 0);
    chk("rst_in_stall", bus.in_stall, 0);
    chk("rst_in_data", bus.in_data, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_led", bus.led, 0);
    chk("rst_rx_overflow", bus.rx_overflow, 0);
    rst = 1'b0;
    bus.status = '0;

    // Single word, tx_ready high: bytes in c2..c5, idle in c6
    w = 32'h44332211;
    next_cycle();
    bus.out_issued = 1'b1;
    bus.out_data   = w;
    bus.tx_ready   = 1'b1;
    #2 chk("tx1_c0_valid", bus.tx_valid, 0);
    next_cycle();
    bus.out_issued = 1'b0;
    #2 chk("tx1_c1_valid", bus.tx_valid, 0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      #2;
      chk("tx1_valid", bus.tx_valid, 1);
      chk("tx1_byte", bus.tx_data, w[8*k +: 8]);
    end
    next_cycle();
    #2 chk("tx1_c6_valid", bus.tx_valid, 0);

    // LED latency
    next_cycle();
    bus.status = 32'h0000_00A5;
    next_cycle();
    #2 chk("led_a5", bus.led, 32'hA5);

    // RX assembly and empty-FIFO stall
    send_word(32'hDEADBEEF);
    bus.in_issued = 1'b1;
    #2;
    chk("rx1_in_stall", bus.in_stall, 0);
    chk("rx1_in_data", bus.in_data, 32'hDEADBEEF);
    next_cycle();
    #2;
    chk("rx1_empty_stall", bus.in_stall, 1);
    chk("rx1_empty_data", bus.in_data, 0);
    bus.in_issued = 1'b0;

    // Back-to-back writes with tx_ready low: 16 in FIFO plus one held in the serializer
    for (int i = 0; i < 18; i++) tw[i] = $urandom;
    exp_bytes.delete();
    accepted = 0;
    next_cycle();
    bus.tx_ready = 1'b0;
    for (int cyc = 0; cyc < 40 && accepted < 17; cyc++) begin
      next_cycle();
      bus.out_issued = 1'b1;
      bus.out_data   = tw[accepted];
      #2;
      chk("tx_fill_nostall", bus.out_stall, 0);
      if (!bus.out_stall) begin
        push_word_bytes(tw[accepted]);
        accepted++;
      end
    end
    chk("tx_fill_accepted", accepted, 17);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      bus.out_data = tw[17];
      #2;
      chk("tx_full_stall", bus.out_stall, 1);
      chk("tx_full_hold_valid", bus.tx_valid, 1);
      chk("tx_full_hold_data", bus.tx_data, exp_bytes[0]);
    end
    pending = 1'b1;
    for (int cyc = 0; cyc < 200 && (exp_bytes.size() > 0 || pending); cyc++) begin
      next_cycle();
      bus.out_issued = pending;
      bus.tx_ready   = 1'b1;
      #2;
      if (pending && !bus.out_stall) begin
        push_word_bytes(tw[17]);
        pending = 1'b0;
      end
      if (exp_bytes.size() > 0) chk("tx_nobubble", bus.tx_valid, 1);
      if (bus.tx_valid) begin
        if (exp_bytes.size() == 0) chk("tx_extra_byte", 1, 0);
        else begin
          eb = exp_bytes.pop_front();
          chk("tx_stream_byte", bus.tx_data, eb);
        end
      end
    end
    chk("tx_drained", exp_bytes.size(), 0);
    chk("tx_18th_taken", pending, 0);
    next_cycle();
    bus.out_issued = 1'b0;
    #2 chk("tx_drain_idle", bus.tx_valid, 0);

    // RX FIFO fill, overflow on the 17th word, order intact
    for (int i = 0; i < 17; i++) rw[i] = $urandom;
    for (int i = 0; i < 16; i++) send_word(rw[i]);
    #2 chk("rx_fill_no_ovf", bus.rx_overflow, 0);
    send_word(rw[16]);
    bus.in_issued = 1'b1;
    #2;
    chk("rx_ovf_set", bus.rx_overflow, 1);
    chk("rx_fill_stall", bus.in_stall, 0);
    chk("rx_fill_data", bus.in_data, rw[0]);
    for (int i = 1; i < 16; i++) begin
      next_cycle();
      #2;
      chk("rx_fill_stall", bus.in_stall, 0);
      chk("rx_fill_data", bus.in_data, rw[i]);
    end
    next_cycle();
    #2 chk("rx_fill_drained", bus.in_stall, 1);
    bus.in_issued = 1'b0;

    // Asynchronous reset mid-serialization and mid-word
    next_cycle();
    bus.out_issued = 1'b1;
    bus.out_data   = 32'hCAFEF00D;
    bus.tx_ready   = 1'b1;
    next_cycle();
    bus.out_issued = 1'b0;
    next_cycle();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    next_cycle();
    bus.rx_data  = 8'hBB;
    next_cycle();
    bus.rx_valid = 1'b0;
    #2 chk("mid_byte2", bus.tx_data, 32'hFE);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_valid", bus.tx_valid, 0);
    chk("mid_rst_tx_data", bus.tx_data, 0);
    chk("mid_rst_ovf", bus.rx_overflow, 0);
    next_cycle();
    rst = 1'b0;
    #2 chk("mid_after_tx_valid", bus.tx_valid, 0);
    send_word(32'h04030201);
    bus.in_issued = 1'b1;
    #2;
    chk("mid_clean_stall", bus.in_stall, 0);
    chk("mid_clean_word", bus.in_data, 32'h04030201);
    next_cycle();
    bus.in_issued = 1'b0;
    #2;

    // Randomized run against the queue model
    exp_bytes.delete();
    rx_q.delete();
    part.delete();
    ovf_exp     = 1'b0;
    tx_hold     = 1'b0;
    out_hold    = 1'b0;
    in_hold     = 1'b0;
    prev_status = bus.status;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_p = (cyc < 1500) ? 3 : 20;
      next_cycle();
      if (!out_hold) begin
        bus.out_issued = ($urandom_range(0, 1) == 1);
        bus.out_data   = $urandom;
      end
      if (!in_hold) bus.in_issued = ($urandom_range(0, in_p - 1) == 0);
      bus.tx_ready = ($urandom_range(0, 1) == 1);
      bus.rx_valid = ($urandom_range(0, 2) == 0);
      bus.rx_data  = $urandom;
      bus.status   = $urandom;
      #2;
      chk("rnd_led", bus.led, prev_status[7:0]);
      chk("rnd_in_stall", bus.in_stall, bus.in_issued && (rx_q.size() == 0));
      if (bus.in_issued) chk("rnd_in_data", bus.in_data, (rx_q.size() == 0) ? 32'h0 : rx_q[0]);
      chk("rnd_rx_overflow", bus.rx_overflow, ovf_exp);
      if (tx_hold) begin
        chk("rnd_hold_valid", bus.tx_valid, 1);
        chk("rnd_hold_data", bus.tx_data, held_byte);
      end
      outstanding = (exp_bytes.size() + 3) / 4;
      chk("rnd_stall_occ", bus.out_stall && (outstanding < 16), 0);
      chk("rnd_occ_max", outstanding > 17, 0);
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_bytes.size() == 0) chk("rnd_tx_extra", 1, 0);
        else begin
          eb = exp_bytes.pop_front();
          chk("rnd_tx_byte", bus.tx_data, eb);
        end
      end
      if (bus.out_issued && !bus.out_stall) push_word_bytes(bus.out_data);
      full_before = (rx_q.size() == 16);
      if (bus.in_issued && rx_q.size() != 0) void'(rx_q.pop_front());
      if (bus.rx_valid) begin
        part.push_back(bus.rx_data);
        if (part.size() == 4) begin
          if (full_before) ovf_exp = 1'b1;
          else rx_q.push_back({part[3], part[2], part[1], part[0]});
          part.delete();
        end
      end
      tx_hold     = bus.tx_valid && !bus.tx_ready;
      held_byte   = bus.tx_data;
      out_hold    = bus.out_issued && bus.out_stall;
      in_hold     = bus.in_issued && bus.in_stall;
      prev_status = bus.status;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
